// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes, an accumulate (reduction-chain)
// mode and registered zero/all-ones flags.
module logic_unit_pipe #(
    parameter int unsigned word_size = 32,
    parameter int unsigned cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 acc,
    input  logic                 last,
    input  logic [word_size-1:0] R2,
    input  logic [word_size-1:0] R3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] logic_out,
    output logic                 zero_flag,
    output logic                 ones_flag,
    output logic [cnt_width-1:0] chain_len
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    function automatic logic [word_size-1:0] logic_fn(input logic [2:0]           sel,
                                                      input logic [word_size-1:0] a,
                                                      input logic [word_size-1:0] b);
        logic [word_size-1:0] r;
        unique case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    state_e               state_q, state_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic                 s1_acc_q, s1_acc_d;
    logic                 s1_last_q, s1_last_d;
    logic [word_size-1:0] s1_r2_q, s1_r2_d;
    logic [word_size-1:0] s1_r3_q, s1_r3_d;
    logic [word_size-1:0] accum_q, accum_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [word_size-1:0] logic_out_q, logic_out_d;
    logic                 zero_q, zero_d;
    logic                 ones_q, ones_d;
    logic [cnt_width-1:0] chain_len_q, chain_len_d;

    logic [word_size-1:0] opnd_a;
    logic [word_size-1:0] res;
    logic [cnt_width-1:0] cnt_inc;
    logic                 produces;
    logic                 s1_advance;
    logic                 accept;

    always_comb begin
        opnd_a     = (state_q == StAcc) ? accum_q : s1_r2_q;
        res        = logic_fn(s1_op_q, opnd_a, s1_r3_q);
        cnt_inc    = (cnt_q == {cnt_width{1'b1}}) ? cnt_q : cnt_q + cnt_width'(1);
        // In IDLE an acc beat that is also last collapses to a single-beat result.
        produces   = (state_q == StAcc) ? s1_last_q : (!s1_acc_q || s1_last_q);
        s1_advance = s1_valid_q && (!produces || !out_valid_q || out_ready);
        in_ready   = rst_n && (!s1_valid_q || s1_advance);
        accept     = in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_acc_d    = s1_acc_q;
        s1_last_d   = s1_last_q;
        s1_r2_d     = s1_r2_q;
        s1_r3_d     = s1_r3_q;
        accum_d     = accum_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        logic_out_d = logic_out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        chain_len_d = chain_len_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_acc_d   = acc;
            s1_last_d  = last;
            s1_r2_d    = R2;
            s1_r3_d    = R3;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_advance) begin
            if (produces) begin
                out_valid_d = 1'b1;
                logic_out_d = res;
                zero_d      = (res == '0);
                ones_d      = &res;
                chain_len_d = (state_q == StAcc) ? cnt_inc : cnt_width'(1);
                state_d     = StIdle;
            end else begin
                accum_d = res;
                cnt_d   = (state_q == StAcc) ? cnt_inc : cnt_width'(1);
                state_d = StAcc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_acc_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_r2_q     <= '0;
            s1_r3_q     <= '0;
            accum_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            logic_out_q <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            chain_len_q <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_acc_q    <= s1_acc_d;
            s1_last_q   <= s1_last_d;
            s1_r2_q     <= s1_r2_d;
            s1_r3_q     <= s1_r3_d;
            accum_q     <= accum_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            logic_out_q <= logic_out_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            chain_len_q <= chain_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign logic_out = logic_out_q;
    assign zero_flag = zero_q;
    assign ones_flag = ones_q;
    assign chain_len = chain_len_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed table, chain/back-pressure/saturation/reset sequences,
// and randomized beats checked against a queue-based reference model.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [2:0]  op;
    logic        acc, last;
    logic [31:0] R2, R3;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] logic_out, logic_out2;
    logic        zero_flag, zero_flag2, ones_flag, ones_flag2;
    logic [7:0]  chain_len;
    logic [1:0]  chain_len2;

    always #5 clk = ~clk;

    logic_unit_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc(acc), .last(last), .R2(R2), .R3(R3), .out_valid(out_valid),
        .out_ready(out_ready), .logic_out(logic_out), .zero_flag(zero_flag),
        .ones_flag(ones_flag), .chain_len(chain_len)
    );

    logic_unit_pipe #(.word_size(32), .cnt_width(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
        .acc(acc), .last(last), .R2(R2), .R3(R3), .out_valid(out_valid2),
        .out_ready(out_ready), .logic_out(logic_out2), .zero_flag(zero_flag2),
        .ones_flag(ones_flag2), .chain_len(chain_len2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    // Reference model: chain state plus a queue of results still owed by the DUT.
    typedef struct { logic [31:0] v; int n; } exp_t;
    exp_t        expq[$];
    logic [31:0] obs[$];
    bit          m_chain = 0;
    logic [31:0] m_acc;
    int          m_n;

    task automatic model_beat(input logic [2:0] o, input logic a, input logic l,
                              input logic [31:0] r2v, input logic [31:0] r3v);
        logic [31:0] v;
        exp_t e;
        if (!m_chain) begin
            v = ref_f(o, r2v, r3v);
            if (a && !l) begin
                m_chain = 1; m_acc = v; m_n = 1;
            end else begin
                e.v = v; e.n = 1; expq.push_back(e);
            end
        end else begin
            v = ref_f(o, m_acc, r3v);
            m_n++;
            if (l) begin
                e.v = v; e.n = m_n; expq.push_back(e); m_chain = 0;
            end else begin
                m_acc = v;
            end
        end
    endtask

    // Called right after a negedge; returns right after the negedge following acceptance.
    task automatic send(input logic [2:0] o, input logic a, input logic l,
                        input logic [31:0] r2v, input logic [31:0] r3v);
        bit done = 0;
        in_valid = 1; op = o; acc = a; last = l; R2 = r2v; R3 = r3v;
        for (int i = 0; i < 200; i++) begin
            #4;
            if (in_ready) begin
                model_beat(o, a, l, r2v, r3v);
                done = 1;
            end
            @(negedge clk);
            if (done) break;
        end
        if (!done) chk("send_accept", in_ready, 1);
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 300; i++) begin
            if (expq.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        if (i == 300) chk("drain_timeout", expq.size(), 0);
        @(negedge clk);
    endtask

    // Output monitor, sampling 1 time unit before each rising edge.
    bit          held = 0;
    logic [31:0] held_val;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (held) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_hold", logic_out, held_val);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_out", out_valid, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("result", logic_out, e.v);
                        chk("zero_flag", zero_flag, e.v == 32'h0);
                        chk("ones_flag", ones_flag, &e.v);
                        chk("chain_len", chain_len, mn(e.n, 255));
                        chk("chain_len_sat", chain_len2, mn(e.n, 3));
                    end
                    obs.push_back(logic_out);
                end
                held = out_valid && !out_ready;
                held_val = logic_out;
            end else begin
                held = 0;
            end
        end
    end

    typedef struct { logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t tab[10];
    bit   rdone;

    initial begin
        time t0, t1;
        tab[0] = '{3'd0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200};
        tab[1] = '{3'd1, 32'hF0F0_1234, 32'hFF00_FF00, 32'hFFF0_FF34};
        tab[2] = '{3'd2, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0FF0_ED34};
        tab[3] = '{3'd3, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0FFF_EDFF};
        tab[4] = '{3'd4, 32'hF0F0_1234, 32'hFF00_FF00, 32'h000F_00CB};
        tab[5] = '{3'd5, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF00F_12CB};
        tab[6] = '{3'd6, 32'hF0F0_1234, 32'hFF00_FF00, 32'h00F0_0034};
        tab[7] = '{3'd7, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF0F0_1234};
        tab[8] = '{3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000};
        tab[9] = '{3'd5, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF};

        rst_n = 0; in_valid = 0; op = 0; acc = 0; last = 0; R2 = 0; R3 = 0; out_ready = 1;
        @(negedge clk); #4;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {logic_out, zero_flag, ones_flag, chain_len}, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("in_ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Latency: accepted at edge t, visible after edge t+1.
        send(3'd2, 0, 0, 32'h0000_FFFF, 32'h00FF_00FF);
        #4 chk("latency_early", out_valid, 0);
        @(negedge clk); #4 chk("latency_due", out_valid, 1);
        @(negedge clk);
        wait_drain();

        // All ops and flag rows back-to-back.
        obs.delete();
        t0 = $time;
        for (int i = 0; i < 10; i++) send(tab[i].o, 0, 0, tab[i].a, tab[i].b);
        t1 = $time;
        chk("throughput", (t1 - t0) / 10, 10);
        wait_drain();
        for (int i = 0; i < 10; i++) chk("table_op", obs[i], tab[i].exp);
        chk("ones_flag_final", {ones_flag, zero_flag}, 2'b10);

        // AND accumulate chain.
        obs.delete();
        send(3'd0, 1, 0, 32'hFFFF_FFFF, 32'h0F0F_FFFF);
        send(3'd0, 0, 0, 32'h1357_9BDF, 32'h00FF_FFFF);
        send(3'd0, 1, 1, 32'h0000_0000, 32'hFFFF_000F);
        wait_drain();
        chk("chain_count", obs.size(), 1);
        chk("chain_value", obs[0], 32'h000F_000F);
        chk("chain_len3", chain_len, 3);

        // Back-pressure: 5 stalled cycles while four beats are offered.
        obs.delete();
        out_ready = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(tab[i].o, 0, 0, tab[i].a, tab[i].b);
            end
            begin
                repeat (2) @(negedge clk);
                #4 chk("bp_in_ready_low", in_ready, 0);
                repeat (3) @(negedge clk);
                out_ready = 1;
            end
        join
        wait_drain();
        chk("bp_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_order", obs[i], tab[i].exp);

        // Counter saturation: 6-beat OR chain, then a 1-beat chain.
        send(3'd1, 1, 0, 32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 4; i++) send(3'd1, 0, 0, 32'h0, 32'h1 << (i + 2));
        send(3'd1, 0, 1, 32'h0, 32'h8000_0000);
        wait_drain();
        chk("sat_len6", chain_len, 6);
        chk("sat_len_cnt2", chain_len2, 3);
        chk("sat_value", logic_out, 32'h8000_003F);
        send(3'd1, 1, 1, 32'h0000_00F0, 32'h0000_000F);
        wait_drain();
        chk("single_chain_len", {chain_len, 6'h0, chain_len2}, {8'd1, 6'h0, 2'd1});

        // Reset mid-chain.
        obs.delete();
        send(3'd1, 1, 0, 32'h1, 32'h2);
        send(3'd1, 0, 0, 32'h0, 32'h4);
        rst_n = 0;
        m_chain = 0;
        expq.delete();
        #4;
        chk("midrst_in_ready", {in_ready, in_ready2}, 0);
        chk("midrst_outputs", {out_valid, logic_out, zero_flag, ones_flag, chain_len}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(3'd6, 0, 0, 32'hFFFF_0000, 32'h0F0F_0F0F);
        wait_drain();
        chk("post_rst_count", obs.size(), 1);
        chk("post_rst_value", obs[0], 32'hF0F0_0000);
        chk("post_rst_len", chain_len, 1);

        // Randomized beats with random back-pressure.
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 400; i++)
                    send(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                         $urandom_range(0, 2) == 0, $urandom, $urandom);
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    if (!rdone) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1;
        if (m_chain) send(3'd7, 0, 1, 32'h0, 32'h0);
        wait_drain();
        chk("random_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit for the ALU datapath. It generalises the plain n-bit AND gate array to eight selectable bitwise operations. It adds valid/ready handshakes on input and output, a multi-beat accumulate (reduction-chain) mode, and registered zero/all-ones flags. It sits between the register-file read ports (R2, R3) and the ALU result mux.

## Interface
- word_size, 32, operand and result width in bits
- cnt_width, 8, width of the chain beat counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat
- op  input  3  operation select, sampled with the beat
- acc  input  1  beat starts an accumulate chain (examined in IDLE only)
- last  input  1  beat ends an accumulate chain
- R2  input  word_size  operand A
- R3  input  word_size  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- logic_out  output  word_size  result
- zero_flag  output  1  logic_out is all zeros
- ones_flag  output  1  logic_out is all ones
- chain_len  output  cnt_width  number of beats folded into logic_out

## Operation
- op encoding, with f(A,B):
  - 000 A&B
  - 001 A|B
  - 010 A^B
  - 011 ~(A&B)
  - 100 ~(A|B)
  - 101 ~(A^B)
  - 110 A&~B
  - 111 A (pass-through)
- Two stages:
  - S1: input register holding op, acc, last, R2 and R3.
  - S2: output register holding logic_out, the flags and chain_len, plus an accumulator register.
- FSM states are IDLE and ACC. Reset state is IDLE.
- IDLE, S1 beat with acc=0:
  - Computes f(R2,R3).
  - Loads it into the output register with chain_len=1.
  - Stays in IDLE.
- IDLE, S1 beat with acc=1 and last=1: handled exactly as acc=0 (single-beat chain, chain_len=1).
- IDLE, S1 beat with acc=1 and last=0:
  - Loads the accumulator with f(R2,R3).
  - Sets the beat counter to 1.
  - Moves to ACC.
  - Produces no output.
- ACC, any S1 beat:
  - Operand A is the accumulator and operand B is R3. R2 and acc are ignored.
  - The beat's own op is used, so the op may change mid-chain.
  - Beat counter increments and saturates at 2^cnt_width−1.
  - last=0: updates the accumulator and stays in ACC. No output.
  - last=1: loads f(acc,R3) into the output register, with chain_len = counter+1 (saturating). Returns to IDLE.
- Flags are computed from the value written into logic_out and registered with it.
- Advance rules:
  - A result-producing S1 beat advances only when !out_valid || out_ready.
  - A non-producing S1 beat (chain start or continue) always advances.
- in_ready = rst_n && (!s1_valid || s1_advance).
- Output holds stable while out_valid && !out_ready.
- Reset values:
  - out_valid=0, logic_out=0, zero_flag=0, ones_flag=0, chain_len=0.
  - Accumulator 0, counter 0, S1 empty, state IDLE.
  - in_ready=0 while rst_n is low.
- Reset asserted mid-chain discards the chain and any held result. No partial output is ever emitted.

## Timing
- A beat accepted at edge t (in_valid && in_ready) is in S1 after edge t.
- If it produces a result, out_valid rises after edge t+1 when downstream is unblocked. Latency is 2 edges.
- Throughput is one beat per clock with out_ready held high, including back-to-back chains.
- An out_ready stall propagates to in_ready combinationally in the same cycle. No beat is dropped or duplicated.
- Output handshake completes on an edge with out_valid && out_ready. A new result may load on that same edge.
- in_valid and all beat fields must be held stable until accepted.
- in_ready rises in the first cycle after rst_n deasserts.

## Test plan
- **All ops, width 32.** R2=0xF0F0_1234, R3=0xFF00_FF00, op 000…111 back-to-back with out_ready=1. Required results, one per clock with latency 2: 0xF000_1200, 0xFFF0_FF34, 0x0FF0_ED34, 0x0FFF_EDFF, 0x000F_00CB, 0xF00F_12CB, 0x00F0_0034, 0xF0F0_1234.
- **Flags.** AND of 0xAAAA_AAAA with 0x5555_5555 gives logic_out=0, zero_flag=1, ones_flag=0. XNOR of equal operands gives 0xFFFF_FFFF, ones_flag=1.
- **Accumulate chain, op=AND.** Beat 1: R2=0xFFFF_FFFF, R3=0x0F0F_FFFF. Beat 2: R3=0x00FF_FFFF. Beat 3: R3=0xFFFF_000F, last=1. Exactly one output: 0x000F_000F, chain_len=3.
- **Back-pressure.** out_ready=0 for 5 cycles while feeding 4 beats. in_ready drops, logic_out stays stable, and all 4 results emerge in order once out_ready=1.
- **Counter saturation.** cnt_width=2, 6-beat OR chain: chain_len=3. A 1-beat chain with acc=1, last=1 gives chain_len=1.
- **Reset mid-chain.** Pulse rst_n low after beat 2 of a 4-beat chain. All outputs read 0 and in_ready=0 during reset. A fresh acc=0 beat then produces a correct single result with chain_len=1 and no stale chain output.
